// File: rtl/cnn_pkg.sv
// Shared layer-2 constants for the conv2 -> maxpool -> LRN/conv3 path.
package cnn_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned L2_IMG_W    = 27;
    localparam int unsigned L2_IMG_H    = 27;
    localparam int unsigned L2_OUT_W    = 13;
    localparam int unsigned L2_OUT_H    = 13;
    localparam int unsigned L2_CHANNELS = 256;

endpackage

// File: rtl/maxpool3s2_stream_max2_s.sv
// Combinational signed two-input maximum.
module max2_s #(
    parameter int unsigned DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] max_c
);

    assign max_c = (a > b) ? a : b;

endmodule

// File: rtl/maxpool3s2_stream.sv
// Streaming 3x3 stride-2 max-pool over one raster-ordered plane at a time,
// with a single registered output slot.
module maxpool3s2_stream #(
    parameter int unsigned DATA_W = cnn_pkg::DATA_W,
    parameter int unsigned IMG_W  = cnn_pkg::L2_IMG_W,
    parameter int unsigned IMG_H  = cnn_pkg::L2_IMG_H
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int unsigned OUT_W = (IMG_W - 1) / 2;
    localparam int unsigned CW    = $clog2(IMG_W);
    localparam int unsigned RW    = $clog2(IMG_H);
    localparam int unsigned OCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic signed [DATA_W-1:0] hacc_q, hacc_d;
    logic signed [DATA_W-1:0] vacc_q [OUT_W];
    logic signed [DATA_W-1:0] vacc_d [OUT_W];
    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     out_last_q, out_last_d;

    logic                     accept_c;
    logic                     win_done_c;
    logic [OCW-1:0]           oc_c;
    logic signed [DATA_W-1:0] in_s_c;
    logic signed [DATA_W-1:0] h_max_c;
    logic signed [DATA_W-1:0] h_c;
    logic signed [DATA_W-1:0] vacc_rd_c;
    logic signed [DATA_W-1:0] v_max_c;

    assign in_ready   = !rst && (!out_valid_q || out_ready);
    assign accept_c   = in_valid && in_ready;
    assign in_s_c     = $signed(in_data);
    assign win_done_c = (col_q != '0) && !col_q[0];
    assign oc_c       = win_done_c ? OCW'(col_q[CW-1:1] - (CW-1)'(1)) : '0;
    assign h_c        = (col_q == '0) ? in_s_c : h_max_c;
    assign vacc_rd_c  = vacc_q[oc_c];

    max2_s #(.DATA_W(DATA_W)) u_hmax (.a(hacc_q),    .b(in_s_c), .max_c(h_max_c));
    max2_s #(.DATA_W(DATA_W)) u_vmax (.a(vacc_rd_c), .b(h_c),    .max_c(v_max_c));

    // Counters, horizontal/vertical accumulation and the output slot.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hacc_d      = hacc_q;
        vacc_d      = vacc_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q && !out_ready;

        if (accept_c) begin
            // Odd column extends the window; col 0 and shared even columns restart it.
            hacc_d = col_q[0] ? h_c : in_s_c;

            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (win_done_c) begin
                if (row_q == '0) begin
                    vacc_d[oc_c] = h_c;
                end else if (row_q[0]) begin
                    vacc_d[oc_c] = v_max_c;
                end else begin
                    out_valid_d  = 1'b1;
                    out_data_d   = v_max_c;
                    out_last_d   = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
                    vacc_d[oc_c] = h_c;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            hacc_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hacc_q      <= hacc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Row buffer is always written at row 0 before it is read, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(OUT_W); i++) begin
            vacc_q[i] <= vacc_d[i];
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool3s2_stream.sv
// Scoreboard bench for maxpool3s2_stream: window maxima computed from the stored plane.
module tb_maxpool3s2_stream;

    localparam int DW   = 16;
    localparam int IW   = 27;
    localparam int IH   = 27;
    localparam int NOUT = 169;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t sb_q[$];
    int   out_log[$];
    int   img[IH][IW];
    int   mr, mc, beats, last_cnt;
    int   n_checks, n_errors;

    maxpool3s2_stream dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pix(input int mode, input int r, input int c, input int off);
        case (mode)
            1:       return (r == 2 && c == 2) ? 100 : 0;
            2:       return (r == 26 && c == 26) ? -1 : -5;
            default: return r * 27 + c + off;
        endcase
    endfunction

    function automatic int win_max(input int r, input int c);
        int m;
        m = img[r-2][c-2];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (img[r-2+i][c-2+j] > m) m = img[r-2+i][c-2+j];
        return m;
    endfunction

    // Evaluate the handshakes that the coming rising edge will perform.
    task automatic observe();
        exp_t e;
        if (out_valid && !out_ready) check("stall_in_ready", int'(in_ready), 0);
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("out_data", int'($signed(out_data)), e.data);
                check("out_last", int'(out_last), int'(e.last));
                out_log.push_back(int'($signed(out_data)));
                if (out_last) last_cnt++;
            end
        end
        if (in_valid && in_ready) begin
            img[mr][mc] = int'($signed(in_data));
            if (mr >= 2 && mr % 2 == 0 && mc >= 2 && mc % 2 == 0) begin
                e.data = win_max(mr, mc);
                e.last = (mr == IH - 1) && (mc == IW - 1);
                sb_q.push_back(e);
            end
            if (mc == IW - 1) begin
                mc = 0;
                mr = (mr == IH - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
            beats++;
        end
    endtask

    task automatic send(input int mode, input int off, input bit rnd, input int n);
        int b0;
        int guard;
        b0 = beats;
        guard = 0;
        while (beats - b0 < n && guard < 20000) begin
            @(negedge clk);
            in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data   = in_valid ? DW'(pix(mode, mr, mc, off)) : DW'($urandom);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            observe();
            guard++;
        end
        if (guard >= 20000) check("send_timeout", beats - b0, n);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() > 0 && guard < 1000) begin
            @(negedge clk);
            in_valid  = 1'b0;
            in_data   = DW'($urandom);
            out_ready = 1'b1;
            #1;
            observe();
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("drain_empty", sb_q.size(), 0);
    endtask

    task automatic begin_test();
        out_log.delete();
        last_cnt = 0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        mr        = 0;
        mc        = 0;
        beats     = 0;
        last_cnt  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;

        // Ramp plane, continuous flow.
        begin_test();
        send(0, 0, 1'b0, IW * IH);
        drain();
        check("ramp_count", out_log.size(), NOUT);
        check("ramp_first", out_log[0], 56);
        check("ramp_final", out_log[NOUT-1], 728);
        check("ramp_last_cnt", last_cnt, 1);

        // Single peak shared between four windows.
        begin_test();
        send(1, 0, 1'b0, IW * IH);
        drain();
        check("edge_count", out_log.size(), NOUT);
        check("edge_00", out_log[0], 100);
        check("edge_01", out_log[1], 100);
        check("edge_10", out_log[13], 100);
        check("edge_11", out_log[14], 100);
        check("edge_02", out_log[2], 0);
        check("edge_22", out_log[28], 0);

        // Negative plane.
        begin_test();
        send(2, 0, 1'b0, IW * IH);
        drain();
        check("neg_first", out_log[0], -5);
        check("neg_final", out_log[NOUT-1], -1);
        check("neg_last_cnt", last_cnt, 1);

        // Ramp plane with random valid/ready.
        begin_test();
        send(0, 0, 1'b1, IW * IH);
        drain();
        check("bp_count", out_log.size(), NOUT);
        for (int i = 0; i < 13; i++)
            for (int j = 0; j < 13; j++)
                check("bp_ramp", out_log[i*13+j], (2*i+2)*27 + 2*j + 2);

        // Two planes back to back.
        begin_test();
        send(0, 0, 1'b0, IW * IH);
        send(0, 1000, 1'b0, IW * IH);
        drain();
        check("b2b_count", out_log.size(), 2 * NOUT);
        check("b2b_second_first", out_log[NOUT], 1056);
        check("b2b_last_cnt", last_cnt, 2);

        // Reset in the middle of a plane.
        begin_test();
        send(0, 0, 1'b0, 400);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        sb_q.delete();
        mr = 0;
        mc = 0;
        begin_test();
        send(0, 0, 1'b0, IW * IH);
        drain();
        check("rst_plane_count", out_log.size(), NOUT);
        check("rst_plane_first", out_log[0], 56);
        check("rst_plane_final", out_log[NOUT-1], 728);
        check("rst_plane_last_cnt", last_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
